// File: rtl/nn_pkg.sv
// Shared constants and types for the NN output argmax block.
// Holds float widths, ordering-key sign mask and the FSM state enum.
package nn_pkg;

  localparam int FP_W = 32;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;
  localparam logic [FP_W-1:0] KEY_SIGN = 32'h8000_0000;

  localparam int VEC_LEN_DEF = 3;
  localparam int STEPS_DEF = 3;

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

endpackage

// File: rtl/fp_order_key.sv
// Float word to unsigned ordering key, zero/denormal flushed to +0.
// Also flags NaN patterns (exponent all ones, mantissa nonzero).
module fp_order_key
  import nn_pkg::*;
#(
  parameter int SIG_W = 23,
  parameter int EXP_W = 8
) (
  input  logic [SIG_W+EXP_W:0] word_i,
  output logic [SIG_W+EXP_W:0] key_o,
  output logic                 nan_o
);

  localparam int DW = SIG_W + EXP_W + 1;
  localparam logic [DW-1:0] SMASK = DW'(KEY_SIGN);

  logic [EXP_W-1:0] exp_w;
  logic [SIG_W-1:0] man_w;
  logic [DW-1:0]    ftz_w;

  assign exp_w = word_i[DW-2 -: EXP_W];
  assign man_w = word_i[SIG_W-1:0];

  // flush, then map sign-magnitude onto an unsigned order
  always_comb begin
    ftz_w = (exp_w == '0) ? '0 : word_i;
    key_o = ftz_w[DW-1] ? ~ftz_w : (ftz_w ^ SMASK);
  end

  assign nan_o = (exp_w == EXP_W'(EXP_ALL1)) && (man_w != '0);

endmodule

// File: rtl/nn_out_argmax.sv
// Per-vector and per-frame argmax over the NN cell output stream.
// Optional NaN flag output enabled by NN_ARGMAX_NAN_FLAG_EN.
module nn_out_argmax
  import nn_pkg::*;
#(
  parameter int inst_sig_width = 23,
  parameter int inst_exp_width = 8,
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int STEPS = STEPS_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [inst_sig_width+inst_exp_width:0] in_data,
  output logic                                 out_valid,
  output logic [2:0]                           out_idx,
  output logic [inst_sig_width+inst_exp_width:0] out_max,
  output logic                                 frame_done,
  output logic [2:0]                           frame_step
`ifdef NN_ARGMAX_NAN_FLAG_EN
  ,
  output logic                                 out_nan
`endif
);

  localparam int DW = inst_sig_width + inst_exp_width + 1;
  localparam logic [2:0] ELEM_LAST = 3'(VEC_LEN - 1);
  localparam logic [2:0] STEP_LAST = 3'(STEPS - 1);

  state_t state_q, state_d;
  logic [2:0] elem_q, elem_d;
  logic [2:0] step_q, step_d;
  logic [DW-1:0] run_max_q, run_max_d;
  logic [2:0] run_idx_q, run_idx_d;
  logic [DW-1:0] res_max_q, res_max_d;
  logic [2:0] res_idx_q, res_idx_d;
  logic res_last_q, res_last_d;
  logic [2:0] res_step_q, res_step_d;
  logic [DW-1:0] frm_key_q, frm_key_d;
  logic [2:0] frm_step_q, frm_step_d;

  logic [DW-1:0] in_key, max_key, win_key;
  logic [DW-1:0] win_max;
  logic [2:0] win_idx;
  logic last_elem, last_step, take, frm_take;

`ifdef NN_ARGMAX_NAN_FLAG_EN
  logic in_nan, max_nan;
  logic run_nan_q, run_nan_d;
  logic res_nan_q, res_nan_d;
`endif

  fp_order_key #(
    .SIG_W(inst_sig_width),
    .EXP_W(inst_exp_width)
  ) u_key_in (
    .word_i(in_data),
    .key_o (in_key),
`ifdef NN_ARGMAX_NAN_FLAG_EN
    .nan_o (in_nan)
`else
    .nan_o ()
`endif
  );

  fp_order_key #(
    .SIG_W(inst_sig_width),
    .EXP_W(inst_exp_width)
  ) u_key_max (
    .word_i(run_max_q),
    .key_o (max_key),
`ifdef NN_ARGMAX_NAN_FLAG_EN
    .nan_o (max_nan)
`else
    .nan_o ()
`endif
  );

  // running max, counters and result capture
  always_comb begin
    last_elem = (elem_q == ELEM_LAST);
    last_step = (step_q == STEP_LAST);
`ifdef NN_ARGMAX_NAN_FLAG_EN
    take = (elem_q == '0) ||
           (!in_nan && (max_nan || (in_key > max_key)));
`else
    take = (elem_q == '0) || (in_key > max_key);
`endif
    win_max = take ? in_data : run_max_q;
    win_idx = take ? elem_q : run_idx_q;
    win_key = take ? in_key : max_key;
    frm_take = (step_q == '0) || (win_key > frm_key_q);

    elem_d = elem_q;
    step_d = step_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    res_max_d = res_max_q;
    res_idx_d = res_idx_q;
    res_last_d = res_last_q;
    res_step_d = res_step_q;
    frm_key_d = frm_key_q;
    frm_step_d = frm_step_q;
`ifdef NN_ARGMAX_NAN_FLAG_EN
    run_nan_d = run_nan_q;
    res_nan_d = res_nan_q;
`endif

    if (in_valid) begin
      elem_d = last_elem ? 3'd0 : elem_q + 3'd1;
      run_max_d = win_max;
      run_idx_d = win_idx;
`ifdef NN_ARGMAX_NAN_FLAG_EN
      run_nan_d = ((elem_q == '0) ? 1'b0 : run_nan_q) | in_nan;
`endif
      if (last_elem) begin
        step_d = last_step ? 3'd0 : step_q + 3'd1;
        res_max_d = win_max;
        res_idx_d = win_idx;
        res_last_d = last_step;
        res_step_d = frm_take ? step_q : frm_step_q;
`ifdef NN_ARGMAX_NAN_FLAG_EN
        res_nan_d = run_nan_d;
`endif
        if (frm_take) begin
          frm_key_d = win_key;
          frm_step_d = step_q;
        end
      end
    end
  end

  // report FSM: next state and zero-when-idle outputs
  always_comb begin
    state_d = state_q;
    out_valid = 1'b0;
    out_idx = '0;
    out_max = '0;
    frame_done = 1'b0;
    frame_step = '0;
`ifdef NN_ARGMAX_NAN_FLAG_EN
    out_nan = 1'b0;
`endif
    unique case (state_q)
      ACCUM: begin
        if (in_valid && last_elem) state_d = REPORT;
      end
      REPORT: begin
        state_d = ACCUM;
        out_valid = 1'b1;
        out_idx = res_idx_q;
        out_max = res_max_q;
        frame_done = res_last_q;
        frame_step = res_last_q ? res_step_q : 3'd0;
`ifdef NN_ARGMAX_NAN_FLAG_EN
        out_nan = res_nan_q;
`endif
      end
      default: state_d = ACCUM;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      elem_q <= '0;
      step_q <= '0;
      run_max_q <= '0;
      run_idx_q <= '0;
      res_max_q <= '0;
      res_idx_q <= '0;
      res_last_q <= 1'b0;
      res_step_q <= '0;
      frm_key_q <= '0;
      frm_step_q <= '0;
`ifdef NN_ARGMAX_NAN_FLAG_EN
      run_nan_q <= 1'b0;
      res_nan_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      elem_q <= elem_d;
      step_q <= step_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
      res_max_q <= res_max_d;
      res_idx_q <= res_idx_d;
      res_last_q <= res_last_d;
      res_step_q <= res_step_d;
      frm_key_q <= frm_key_d;
      frm_step_q <= frm_step_d;
`ifdef NN_ARGMAX_NAN_FLAG_EN
      run_nan_q <= run_nan_d;
      res_nan_q <= res_nan_d;
`endif
    end
  end

endmodule

// File: tb/tb_nn_out_argmax.sv
// Self-checking bench for nn_out_argmax against a real-valued model.
// Honours NN_ARGMAX_NAN_FLAG_EN for the optional NaN flag output.
module tb_nn_out_argmax;

  localparam int VL = 3;
  localparam int ST = 3;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic [31:0] in_data;
  logic out_valid;
  logic [2:0] out_idx;
  logic [31:0] out_max;
  logic frame_done;
  logic [2:0] frame_step;
`ifdef NN_ARGMAX_NAN_FLAG_EN
  logic out_nan;
`endif

  nn_out_argmax dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_max   (out_max),
    .frame_done(frame_done),
    .frame_step(frame_step)
`ifdef NN_ARGMAX_NAN_FLAG_EN
    ,
    .out_nan   (out_nan)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] mx;
    logic        fd;
    logic [2:0]  fs;
    logic        nan;
  } res_t;

  res_t expq[$];
  logic [31:0] vbuf[$];
  real fbest;
  int fbest_step;
  int mstep;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] w);
    return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
  endfunction

  function automatic real fval(input logic [31:0] w);
    real v;
    int e;
    e = int'(w[30:23]);
    if (e == 0) return 0.0;
    v = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return w[31] ? -v : v;
  endfunction

  task automatic model_reset();
    expq.delete();
    vbuf.delete();
    mstep = 0;
    fbest = 0.0;
    fbest_step = 0;
  endtask

  task automatic model_word(input logic [31:0] w);
    res_t r;
    int bi;
    bit anynan;
    bit better;
    vbuf.push_back(w);
    if (vbuf.size() == VL) begin
      bi = 0;
      anynan = is_nan(vbuf[0]);
      for (int i = 1; i < VL; i++) begin
        anynan |= is_nan(vbuf[i]);
`ifdef NN_ARGMAX_NAN_FLAG_EN
        better = !is_nan(vbuf[i]) &&
                 (is_nan(vbuf[bi]) || fval(vbuf[i]) > fval(vbuf[bi]));
`else
        better = fval(vbuf[i]) > fval(vbuf[bi]);
`endif
        if (better) bi = i;
      end
      if (mstep == 0 || fval(vbuf[bi]) > fbest) begin
        fbest = fval(vbuf[bi]);
        fbest_step = mstep;
      end
      r.idx = 3'(bi);
      r.mx = vbuf[bi];
      r.fd = (mstep == ST - 1);
      r.fs = 3'(fbest_step);
      r.nan = anynan;
      expq.push_back(r);
      vbuf.delete();
      mstep = (mstep + 1) % ST;
    end
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data = w;
    in_valid = 1'b1;
    @(posedge clk);
    model_word(w);
    #1;
    in_valid = 1'b0;
    in_data = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] pool [6];
    logic [7:0] e;
    pool[0] = 32'h3F80_0000;
    pool[1] = 32'h4000_0000;
    pool[2] = 32'hBF80_0000;
    pool[3] = 32'h0000_0000;
    pool[4] = 32'h8000_0000;
    pool[5] = 32'h0000_0005;
    if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 5)];
    e = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(100, 150));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // output monitor: exact pulse timing and zeroed idle outputs
  always @(negedge clk) begin : mon
    res_t r;
    if (expq.size() > 0) begin
      r = expq.pop_front();
      check_eq("out_valid", 32'(out_valid), 32'd1);
      check_eq("out_idx", 32'(out_idx), 32'(r.idx));
      check_eq("out_max", out_max, r.mx);
      check_eq("frame_done", 32'(frame_done), 32'(r.fd));
      if (r.fd) check_eq("frame_step", 32'(frame_step), 32'(r.fs));
`ifdef NN_ARGMAX_NAN_FLAG_EN
      check_eq("out_nan", 32'(out_nan), 32'(r.nan));
`endif
    end else begin
      check_eq("idle_valid", 32'(out_valid), 32'd0);
      check_eq("idle_idx", 32'(out_idx), 32'd0);
      check_eq("idle_max", out_max, 32'd0);
      check_eq("idle_fdone", 32'(frame_done), 32'd0);
    end
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_idx", 32'(out_idx), 32'd0);
    check_eq("rst_max", out_max, 32'd0);
    check_eq("rst_fdone", 32'(frame_done), 32'd0);
    check_eq("rst_fstep", 32'(frame_step), 32'd0);
    rst_n = 1'b1;

    send(32'h3F80_0000, 1);
    send(32'h4060_0000, 0);
    send(32'hC000_0000, 0);
    send(32'hC080_0000, 0);
    send(32'hBF00_0000, 0);
    send(32'hBF80_0000, 0);
    send(32'h4000_0000, 0);
    send(32'h4000_0000, 0);
    send(32'h0000_0000, 0);
    send(32'h8000_0000, 0);
    send(32'h0000_0000, 0);
    send(32'h0000_0001, 0);
    repeat (2) @(posedge clk);
    #1;

    do_reset();
    send(32'h4120_0000, 1);
    send(32'h3F80_0000, 0);
    send(32'hC000_0000, 0);
    send(32'h40E0_0000, 2);
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    send(32'h3F80_0000, $urandom_range(0, 4));
    send(32'h3F00_0000, $urandom_range(0, 4));
    send(32'hC040_0000, $urandom_range(0, 4));
    send(32'h40A0_0000, $urandom_range(0, 4));
    send(32'h4000_0000, $urandom_range(0, 4));
    send(32'h40A0_0000, $urandom_range(0, 4));
    send(32'hBF80_0000, $urandom_range(0, 4));
    send(32'h40A0_0000, $urandom_range(0, 4));
    send(32'h4080_0000, $urandom_range(0, 4));

`ifdef NN_ARGMAX_NAN_FLAG_EN
    send(32'h7FC0_0000, 1);
    send(32'h3F80_0000, 0);
    send(32'h3F00_0000, 0);
    send(32'h7FC0_0001, 0);
    send(32'hFF80_0001, 0);
    send(32'h7F80_0002, 0);
`endif

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < VL * ST; i++) begin
        send(rand_word(),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check_eq("drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
